// File: rtl/cr_osf_latency_mon_pkg.sv
// Shared types for the OSF latency monitor: stream bus, TLV word layouts,
// monitor FSM states and the reset value of the latency minimum.
package cr_osf_latency_mon_pkg;

  // Data-path bus as seen at the OSF output mux.
  typedef struct packed {
    logic [63:0] tdata;
    logic [7:0]  tuser;
    logic        tlast;
  } axi4s_dp_bus_t;

  // Side-band markers carried on tuser.
  localparam logic [7:0] AXI4S_SOT = 8'h01;
  localparam logic [7:0] AXI4S_EOT = 8'h02;

  // TLV type encoding.
  typedef enum logic [7:0] {
    TLV_NONE       = 8'h00,
    RQE            = 8'h01,
    STAT           = 8'h02,
    DATA           = 8'h03,
    FRMD_USER_NULL = 8'h04
  } tlv_types_e;

  // TLV header word (word 0).
  typedef struct packed {
    logic [31:0] rsvd;
    logic [15:0] tlv_len;
    logic [7:0]  tlv_eot_rsvd;
    tlv_types_e  tlv_type;
  } tlv_word_0_t;

  // STAT TLV word 2, written by the OSF latency inserter.
  typedef struct packed {
    logic [38:0] rsvd;
    logic        frame_error;
    logic [23:0] latency;
  } tlv_stats_word2_t;

  // Latency monitor FSM states.
  typedef enum logic [1:0] {
    MON_IDLE = 2'd0,
    MON_STAT = 2'd1,
    MON_SKIP = 2'd2
  } osf_lat_mon_st_e;

  // Minimum tracker starts at the largest latency so the first sample wins.
  localparam logic [23:0] OSF_LAT_MON_MIN_RST = 24'hFFFFFF;

endpackage

// File: rtl/cr_osf_lat_mon_acc.sv
// Saturating accumulator: adds value_i when inc_i is set, sticks at all-ones,
// and a synchronous clr_i restarts from zero (a same-cycle increment is
// applied on top of the cleared value).
module cr_osf_lat_mon_acc #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  input  logic [W-1:0] value_i,
  output logic [W-1:0] acc_o
);

  logic [W-1:0] acc_q;
  logic [W-1:0] acc_d;
  logic [W-1:0] base;
  logic [W:0]   sum;

  // Next value: cleared base plus optional increment, clamped on carry-out.
  always_comb begin
    base  = clr_i ? '0 : acc_q;
    sum   = {1'b0, base} + {1'b0, value_i};
    acc_d = base;
    if (inc_i) begin
      acc_d = sum[W] ? '1 : sum[W-1:0];
    end
  end

  // Accumulator register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/cr_osf_latency_mon.sv
// Passive tap on the OSF output stream. Follows STAT TLVs, captures the
// latency/frame_error field of word LAT_WORD and keeps running statistics.
// Stream handshake: a beat is transferred only in a cycle where axi4s_rd_i=1;
// every other cycle is ignored and all state holds. The tap never stalls.
module cr_osf_latency_mon
  import cr_osf_latency_mon_pkg::*;
#(
  parameter int LAT_WORD = 2,
  parameter int SUM_W    = 48,
  parameter int CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  axi4s_dp_bus_t     axi4s_in_i,
  input  logic              axi4s_rd_i,
  input  logic              stat_clr_i,
  output logic              lat_vld_o,
  output logic [23:0]       lat_last_o,
  output logic [23:0]       lat_min_o,
  output logic [23:0]       lat_max_o,
  output logic [SUM_W-1:0]  lat_sum_o,
  output logic [CNT_W-1:0]  lat_cnt_o,
  output logic [CNT_W-1:0]  err_cnt_o,
  output logic [CNT_W-1:0]  trunc_cnt_o,
  output logic [1:0]        mon_state_o
);

  localparam logic [1:0] ST_IDLE = MON_IDLE;
  localparam logic [1:0] ST_STAT = MON_STAT;
  localparam logic [1:0] ST_SKIP = MON_SKIP;

  localparam int             IDX_W   = $clog2(LAT_WORD + 1) + 1;
  localparam logic [IDX_W-1:0] LAT_IDX = IDX_W'(LAT_WORD);

  tlv_word_0_t      word0;
  tlv_stats_word2_t word2;
  logic             beat_sot;
  logic             stat_sot;

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic [1:0]       redec_state;
  logic [IDX_W-1:0] redec_idx;
  logic             redec_trunc;

  logic             capture;
  logic [1:0]       trunc_n;

  logic             lat_vld_q;
  logic [23:0]      last_q, last_d;
  logic [23:0]      min_q, min_d;
  logic [23:0]      max_q, max_d;

  logic             unused_bits;

  assign word0    = tlv_word_0_t'(axi4s_in_i.tdata);
  assign word2    = tlv_stats_word2_t'(axi4s_in_i.tdata);
  assign beat_sot = (axi4s_in_i.tuser == AXI4S_SOT);
  assign stat_sot = beat_sot && (word0.tlv_type == STAT);

  assign unused_bits = ^{word0.rsvd, word0.tlv_len, word0.tlv_eot_rsvd, word2.rsvd};

  // Fresh-TLV decode of the current beat, as seen from MON_IDLE.
  always_comb begin
    redec_state = ST_IDLE;
    redec_idx   = '0;
    redec_trunc = 1'b0;
    if (stat_sot) begin
      if (axi4s_in_i.tlast) begin
        redec_trunc = 1'b1;
      end else begin
        redec_state = ST_STAT;
        redec_idx   = IDX_W'(1);
      end
    end
  end

  // Beat walker: tracks position inside a STAT TLV and flags capture/truncation.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    capture = 1'b0;
    trunc_n = 2'd0;
    if (axi4s_rd_i) begin
      case (state_q)
        ST_STAT: begin
          if (beat_sot) begin
            // Previous STAT lost its tlast before reaching the latency word.
            state_d = redec_state;
            idx_d   = redec_idx;
            trunc_n = 2'd1 + {1'b0, redec_trunc};
          end else if (idx_q == LAT_IDX) begin
            capture = 1'b1;
            idx_d   = idx_q + IDX_W'(1);
            state_d = axi4s_in_i.tlast ? ST_IDLE : ST_SKIP;
          end else if (axi4s_in_i.tlast) begin
            trunc_n = 2'd1;
            state_d = ST_IDLE;
            idx_d   = '0;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
          end
        end
        ST_SKIP: begin
          if (beat_sot) begin
            // Sample already taken, so a missing tlast here is not a truncation.
            state_d = redec_state;
            idx_d   = redec_idx;
            trunc_n = {1'b0, redec_trunc};
          end else if (axi4s_in_i.tlast) begin
            state_d = ST_IDLE;
            idx_d   = '0;
          end
        end
        default: begin
          state_d = redec_state;
          idx_d   = redec_idx;
          trunc_n = {1'b0, redec_trunc};
        end
      endcase
    end
  end

  // FSM and beat index registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Last/min/max: clear first, then fold in a same-cycle sample.
  always_comb begin
    last_d = last_q;
    min_d  = min_q;
    max_d  = max_q;
    if (stat_clr_i) begin
      last_d = '0;
      min_d  = OSF_LAT_MON_MIN_RST;
      max_d  = '0;
    end
    if (capture) begin
      last_d = word2.latency;
      if (word2.latency < min_d) min_d = word2.latency;
      if (word2.latency > max_d) max_d = word2.latency;
    end
  end

  // Sample registers; outputs appear the cycle after the latency beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_vld_q <= 1'b0;
      last_q    <= '0;
      min_q     <= OSF_LAT_MON_MIN_RST;
      max_q     <= '0;
    end else begin
      lat_vld_q <= capture;
      last_q    <= last_d;
      min_q     <= min_d;
      max_q     <= max_d;
    end
  end

  cr_osf_lat_mon_acc #(.W(SUM_W)) u_sum (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (stat_clr_i),
    .inc_i   (capture),
    .value_i (SUM_W'(word2.latency)),
    .acc_o   (lat_sum_o)
  );

  cr_osf_lat_mon_acc #(.W(CNT_W)) u_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (stat_clr_i),
    .inc_i   (capture),
    .value_i (CNT_W'(1)),
    .acc_o   (lat_cnt_o)
  );

  cr_osf_lat_mon_acc #(.W(CNT_W)) u_err (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (stat_clr_i),
    .inc_i   (capture && word2.frame_error),
    .value_i (CNT_W'(1)),
    .acc_o   (err_cnt_o)
  );

  cr_osf_lat_mon_acc #(.W(CNT_W)) u_trunc (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (stat_clr_i),
    .inc_i   (trunc_n != 2'd0),
    .value_i (CNT_W'(trunc_n)),
    .acc_o   (trunc_cnt_o)
  );

  assign lat_vld_o   = lat_vld_q;
  assign lat_last_o  = last_q;
  assign lat_min_o   = min_q;
  assign lat_max_o   = max_q;
  assign mon_state_o = state_q;

endmodule

// File: tb/tb_cr_osf_latency_mon.sv
// Bench for cr_osf_latency_mon: a 48-bit-sum instance and a 26-bit-sum
// instance share one stimulus stream; expectations come from a TLV-level model.
module tb_cr_osf_latency_mon;
  import cr_osf_latency_mon_pkg::*;

  localparam int LAT_WORD = 2;
  localparam int SUM_W    = 48;
  localparam int SUM_S    = 26;
  localparam int CNT_W    = 32;
  localparam longint unsigned SUM_MAX   = (64'd1 << SUM_W) - 1;
  localparam longint unsigned SUM_S_MAX = (64'd1 << SUM_S) - 1;
  localparam longint unsigned CNT_MAX   = (64'd1 << CNT_W) - 1;

  // ---------------- clock / reset / signals ----------------
  logic clk = 1'b0;
  logic rst_n;
  axi4s_dp_bus_t axi4s_in;
  logic axi4s_rd, stat_clr;

  logic              lat_vld, s_lat_vld;
  logic [23:0]       lat_last, lat_min, lat_max, s_lat_last, s_lat_min, s_lat_max;
  logic [SUM_W-1:0]  lat_sum;
  logic [SUM_S-1:0]  s_lat_sum;
  logic [CNT_W-1:0]  lat_cnt, err_cnt, trunc_cnt, s_lat_cnt, s_err_cnt, s_trunc_cnt;
  logic [1:0]        mon_state, s_mon_state;

  always #5 clk = ~clk;

  cr_osf_latency_mon #(.LAT_WORD(LAT_WORD), .SUM_W(SUM_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .axi4s_in_i(axi4s_in), .axi4s_rd_i(axi4s_rd),
    .stat_clr_i(stat_clr), .lat_vld_o(lat_vld), .lat_last_o(lat_last),
    .lat_min_o(lat_min), .lat_max_o(lat_max), .lat_sum_o(lat_sum),
    .lat_cnt_o(lat_cnt), .err_cnt_o(err_cnt), .trunc_cnt_o(trunc_cnt),
    .mon_state_o(mon_state)
  );

  cr_osf_latency_mon #(.LAT_WORD(LAT_WORD), .SUM_W(SUM_S), .CNT_W(CNT_W)) dut_s (
    .clk(clk), .rst_n(rst_n), .axi4s_in_i(axi4s_in), .axi4s_rd_i(axi4s_rd),
    .stat_clr_i(stat_clr), .lat_vld_o(s_lat_vld), .lat_last_o(s_lat_last),
    .lat_min_o(s_lat_min), .lat_max_o(s_lat_max), .lat_sum_o(s_lat_sum),
    .lat_cnt_o(s_lat_cnt), .err_cnt_o(s_err_cnt), .trunc_cnt_o(s_trunc_cnt),
    .mon_state_o(s_mon_state)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- reference model ----------------
  logic [23:0]     m_last, m_min, m_max;
  longint unsigned m_sum, m_sum_s, m_cnt, m_err, m_trunc;

  function automatic longint unsigned sat_add(longint unsigned a, longint unsigned b,
                                              longint unsigned lim);
    return (a + b > lim) ? lim : a + b;
  endfunction

  function automatic void model_clear();
    m_last = 24'h0; m_min = 24'hFFFFFF; m_max = 24'h0;
    m_sum = 0; m_sum_s = 0; m_cnt = 0; m_err = 0; m_trunc = 0;
  endfunction

  function automatic void model_sample(logic [23:0] l, logic fe);
    m_last  = l;
    if (l < m_min) m_min = l;
    if (l > m_max) m_max = l;
    m_sum   = sat_add(m_sum, 64'(l), SUM_MAX);
    m_sum_s = sat_add(m_sum_s, 64'(l), SUM_S_MAX);
    m_cnt   = sat_add(m_cnt, 1, CNT_MAX);
    if (fe) m_err = sat_add(m_err, 1, CNT_MAX);
  endfunction

  function automatic void model_trunc();
    m_trunc = sat_add(m_trunc, 1, CNT_MAX);
  endfunction

  function automatic logic [241:0] exp_snap();
    return {m_last, m_min, m_max, 48'(m_sum), 26'(m_sum_s),
            32'(m_cnt), 32'(m_err), 32'(m_trunc)};
  endfunction

  function automatic logic [241:0] obs_snap();
    return {lat_last, lat_min, lat_max, lat_sum, s_lat_sum, lat_cnt, err_cnt, trunc_cnt};
  endfunction

  function automatic logic [63:0] mk_word0(tlv_types_e t, int len);
    tlv_word_0_t w;
    w.rsvd = $urandom; w.tlv_len = 16'(len); w.tlv_eot_rsvd = 8'h0; w.tlv_type = t;
    return w;
  endfunction

  function automatic logic [63:0] mk_word2(logic [23:0] l, logic fe);
    tlv_stats_word2_t w;
    w.rsvd = 39'({$urandom, $urandom}); w.frame_error = fe; w.latency = l;
    return w;
  endfunction

  // ---------------- driver tasks ----------------
  // One cycle of stimulus; returns #1 after the edge that consumed it.
  task automatic drive_beat(input logic [63:0] d, input logic [7:0] u, input logic l,
                            input logic rd, input logic clr);
    axi4s_in.tdata = d; axi4s_in.tuser = u; axi4s_in.tlast = l;
    axi4s_rd = rd; stat_clr = clr;
    @(posedge clk); #1;
    axi4s_rd = 1'b0; stat_clr = 1'b0;
  endtask

  // Full TLV with optional unqualified gap cycles and optional clear on one beat.
  task automatic send_tlv(input tlv_types_e t, input int len, input logic [23:0] l,
                          input logic fe, input int max_gap, input int clr_beat,
                          input string tag);
    logic [63:0] d;
    logic [7:0]  u;
    logic        exp_vld;
    for (int i = 0; i < len; i++) begin
      repeat ($urandom_range(0, max_gap)) begin
        drive_beat({$urandom, $urandom}, 8'($urandom), 1'($urandom), 1'b0, 1'b0);
        n_checks++;
        if (lat_vld !== 1'b0) $display("FAIL %s_gap_vld obs=%b exp=0", tag, lat_vld);
        else n_pass++;
      end
      d = (i == 0) ? mk_word0(t, len) : (i == LAT_WORD) ? mk_word2(l, fe) : {$urandom, $urandom};
      u = (i == 0) ? AXI4S_SOT : (i == len - 1) ? AXI4S_EOT : 8'h00;
      drive_beat(d, u, (i == len - 1), 1'b1, (i == clr_beat));
      if (i == clr_beat) model_clear();
      exp_vld = (t == STAT) && (len > LAT_WORD) && (i == LAT_WORD);
      if (exp_vld) model_sample(l, fe);
      if ((t == STAT) && (len <= LAT_WORD) && (i == len - 1)) model_trunc();
      n_checks++;
      if (exp_vld) begin
        if ({lat_vld, lat_last} !== {1'b1, l})
          $display("FAIL %s_capture beat=%0d obs vld=%b last=%h exp vld=1 last=%h",
                   tag, i, lat_vld, lat_last, l);
        else n_pass++;
      end else begin
        if (lat_vld !== 1'b0) $display("FAIL %s_vld beat=%0d obs=%b exp=0", tag, i, lat_vld);
        else n_pass++;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    model_clear();
    n_checks++;
    if (obs_snap() !== exp_snap()) $display("FAIL reset_stats obs=%h exp=%h", obs_snap(), exp_snap());
    else n_pass++;
    n_checks++;
    if ({lat_vld, mon_state} !== {1'b0, 2'(MON_IDLE)})
      $display("FAIL reset_vld_state obs=%b/%0d exp=0/0", lat_vld, mon_state);
    else n_pass++;
  endtask

  task automatic test_single();
    send_tlv(STAT, 4, 24'h000123, 1'b0, 0, -1, "single");
    n_checks++;
    if (obs_snap() !== exp_snap()) $display("FAIL single_stats obs=%h exp=%h", obs_snap(), exp_snap());
    else n_pass++;
    n_checks++;
    if ({lat_min, lat_max, lat_cnt} !== {24'h123, 24'h123, 32'd1})
      $display("FAIL single_const obs=%h/%h/%0d exp=123/123/1", lat_min, lat_max, lat_cnt);
    else n_pass++;
  endtask

  task automatic test_multi();
    drive_beat(64'h0, 8'h0, 1'b0, 1'b0, 1'b1);
    model_clear();
    send_tlv(STAT, 4, 24'h10, 1'b0, 2, -1, "multi0");
    send_tlv(STAT, 5, 24'h05, 1'b1, 2, -1, "multi1");
    send_tlv(STAT, 3, 24'h20, 1'b0, 2, -1, "multi2");
    n_checks++;
    if (obs_snap() !== exp_snap()) $display("FAIL multi_stats obs=%h exp=%h", obs_snap(), exp_snap());
    else n_pass++;
    n_checks++;
    if ({lat_min, lat_max, lat_sum[23:0], lat_cnt, err_cnt} !== {24'h5, 24'h20, 24'h35, 32'd3, 32'd1})
      $display("FAIL multi_const obs=%h/%h/%h/%0d/%0d exp=5/20/35/3/1",
               lat_min, lat_max, lat_sum, lat_cnt, err_cnt);
    else n_pass++;
  endtask

  task automatic test_trunc();
    drive_beat(64'h0, 8'h0, 1'b0, 1'b0, 1'b1);
    model_clear();
    send_tlv(STAT, 2, 24'h0, 1'b0, 1, -1, "trunc_w1");
    send_tlv(STAT, 1, 24'h0, 1'b0, 1, -1, "trunc_sot");
    drive_beat(mk_word0(STAT, 4), AXI4S_SOT, 1'b0, 1'b1, 1'b0);
    drive_beat({$urandom, $urandom}, 8'h0, 1'b0, 1'b1, 1'b0);
    model_trunc();
    send_tlv(RQE, 2, 24'h0, 1'b0, 0, -1, "trunc_next");
    n_checks++;
    if (obs_snap() !== exp_snap()) $display("FAIL trunc_stats obs=%h exp=%h", obs_snap(), exp_snap());
    else n_pass++;
    n_checks++;
    if ({trunc_cnt, lat_cnt, lat_min} !== {32'd3, 32'd0, 24'hFFFFFF})
      $display("FAIL trunc_const obs=%0d/%0d/%h exp=3/0/ffffff", trunc_cnt, lat_cnt, lat_min);
    else n_pass++;
  endtask

  task automatic test_rd_qual();
    logic [63:0] w2;
    w2 = mk_word2(24'h0A0B0C, 1'b1);
    drive_beat(mk_word0(STAT, 4), AXI4S_SOT, 1'b0, 1'b1, 1'b0);
    drive_beat({$urandom, $urandom}, 8'h0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive_beat(w2, 8'h0, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (lat_vld !== 1'b0) $display("FAIL rdq_hold_vld cyc=%0d obs=%b exp=0", i, lat_vld);
      else n_pass++;
    end
    n_checks++;
    if (mon_state !== 2'(MON_STAT)) $display("FAIL rdq_state obs=%0d exp=%0d", mon_state, MON_STAT);
    else n_pass++;
    drive_beat(w2, 8'h0, 1'b0, 1'b1, 1'b0);
    model_sample(24'h0A0B0C, 1'b1);
    n_checks++;
    if ({lat_vld, lat_last} !== {1'b1, 24'h0A0B0C})
      $display("FAIL rdq_capture obs=%b/%h exp=1/0a0b0c", lat_vld, lat_last);
    else n_pass++;
    drive_beat({$urandom, $urandom}, AXI4S_EOT, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if (lat_vld !== 1'b0) $display("FAIL rdq_pulse obs=%b exp=0", lat_vld);
    else n_pass++;
    n_checks++;
    if (obs_snap() !== exp_snap()) $display("FAIL rdq_stats obs=%h exp=%h", obs_snap(), exp_snap());
    else n_pass++;
  endtask

  task automatic test_non_stat();
    send_tlv(RQE, 4, 24'hABCDEF, 1'b1, 1, -1, "nonstat_rqe");
    send_tlv(DATA, 4, 24'hABCDEF, 1'b1, 1, -1, "nonstat_data");
    send_tlv(FRMD_USER_NULL, 4, 24'hABCDEF, 1'b1, 1, -1, "nonstat_null");
    n_checks++;
    if (obs_snap() !== exp_snap()) $display("FAIL nonstat_stats obs=%h exp=%h", obs_snap(), exp_snap());
    else n_pass++;
  endtask

  task automatic test_clr_capture();
    send_tlv(STAT, 4, 24'h77, 1'b1, 0, -1, "clr_pre");
    send_tlv(STAT, 4, 24'h42, 1'b0, 0, LAT_WORD, "clr_cap");
    n_checks++;
    if (obs_snap() !== exp_snap()) $display("FAIL clr_cap_stats obs=%h exp=%h", obs_snap(), exp_snap());
    else n_pass++;
    n_checks++;
    if ({lat_cnt, lat_min, lat_max, lat_sum, err_cnt} !== {32'd1, 24'h42, 24'h42, 48'h42, 32'd0})
      $display("FAIL clr_cap_const obs=%0d/%h/%h/%h/%0d exp=1/42/42/42/0",
               lat_cnt, lat_min, lat_max, lat_sum, err_cnt);
    else n_pass++;
    send_tlv(STAT, 2, 24'h0, 1'b0, 0, 1, "clr_trunc");
    n_checks++;
    if (obs_snap() !== exp_snap()) $display("FAIL clr_trunc_stats obs=%h exp=%h", obs_snap(), exp_snap());
    else n_pass++;
  endtask

  task automatic test_sum_sat();
    drive_beat(64'h0, 8'h0, 1'b0, 1'b0, 1'b1);
    model_clear();
    for (int i = 0; i < 4; i++) send_tlv(STAT, 3, 24'hFFFFFF, 1'b0, 0, -1, "sat_fill");
    send_tlv(STAT, 3, 24'h000002, 1'b0, 0, -1, "sat_fill2");
    n_checks++;
    if (s_lat_sum !== 26'h3FFFFFE) $display("FAIL sat_preload obs=%h exp=3fffffe", s_lat_sum);
    else n_pass++;
    send_tlv(STAT, 3, 24'hFFFFFF, 1'b0, 0, -1, "sat_top");
    n_checks++;
    if (s_lat_sum !== 26'h3FFFFFF) $display("FAIL sat_top obs=%h exp=3ffffff", s_lat_sum);
    else n_pass++;
    send_tlv(STAT, 3, 24'h000010, 1'b0, 0, -1, "sat_stick");
    n_checks++;
    if (obs_snap() !== exp_snap()) $display("FAIL sat_stats obs=%h exp=%h", obs_snap(), exp_snap());
    else n_pass++;
  endtask

  task automatic test_random();
    tlv_types_e t;
    int len, cb;
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0: t = RQE;
        1: t = DATA;
        2: t = FRMD_USER_NULL;
        default: t = STAT;
      endcase
      if ($urandom_range(0, 1) == 1) t = STAT;
      len = $urandom_range(1, 6);
      cb  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, len - 1) : -1;
      send_tlv(t, len, 24'($urandom), 1'($urandom), 2, cb, "rand");
      n_checks++;
      if ({mon_state, obs_snap()} !== {2'(MON_IDLE), exp_snap()})
        $display("FAIL rand_stats n=%0d state=%0d obs=%h exp=%h", n, mon_state, obs_snap(), exp_snap());
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    drive_beat(mk_word0(STAT, 4), AXI4S_SOT, 1'b0, 1'b1, 1'b0);
    drive_beat({$urandom, $urandom}, 8'h0, 1'b0, 1'b1, 1'b0);
    rst_n = 1'b0;
    #2;
    model_clear();
    n_checks++;
    if ({mon_state, obs_snap()} !== {2'(MON_IDLE), exp_snap()})
      $display("FAIL rstmid_async state=%0d obs=%h exp=%h", mon_state, obs_snap(), exp_snap());
    else n_pass++;
    #2;
    rst_n = 1'b1;
    drive_beat(mk_word2(24'h55, 1'b1), 8'h0, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (lat_vld !== 1'b0) $display("FAIL rstmid_word2 obs=%b exp=0", lat_vld);
    else n_pass++;
    drive_beat({$urandom, $urandom}, AXI4S_EOT, 1'b1, 1'b1, 1'b0);
    send_tlv(STAT, 3, 24'h66, 1'b0, 1, -1, "rstmid_next");
    n_checks++;
    if (obs_snap() !== exp_snap()) $display("FAIL rstmid_stats obs=%h exp=%h", obs_snap(), exp_snap());
    else n_pass++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst_n = 1'b0;
    axi4s_in = '0;
    axi4s_rd = 1'b0;
    stat_clr = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_single();
    test_multi();
    test_trunc();
    test_rd_qual();
    test_non_stat();
    test_clr_capture();
    test_sum_sat();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
